// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command frame parser.
// - state_e   : parser FSM states
// - Err*      : error codes reported on err_code
// - DefaultHeader : default frame start byte
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCmd     = 3'd1,
    StLen     = 3'd2,
    StPayload = 3'd3,
    StChk     = 3'd4
  } state_e;

  localparam logic [1:0] ErrLen = 2'd1;
  localparam logic [1:0] ErrChk = 2'd2;
  localparam logic [1:0] ErrTo  = 2'd3;

  localparam logic [7:0] DefaultHeader = 8'hAA;

endpackage

// File: rtl/uart_cmd_parser.sv
// Byte-level command frame parser fed by a UART receiver strobe.
// Frame: HEADER, CMD, LEN, LEN payload bytes, CHK (8-bit additive sum of CMD, LEN, payload).
// Ports:
//   sys_clk, sys_rst_n          : clock, asynchronous active-low reset
//   uart_rx_done, uart_rx_data  : one-cycle byte strobe and byte from the receiver
//   cmd_valid                   : one-cycle strobe for a good frame
//   cmd_code, cmd_len, cmd_payload : contents of the last good frame (byte 0 in [7:0])
//   frame_err, err_code         : one-cycle drop strobe; code of the last error (held)
//   busy                        : high whenever a frame is in progress
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned CLK_FRE       = 50_000_000,
  parameter int unsigned BPS           = 9_600,
  parameter logic [7:0]  HEADER        = DefaultHeader,
  parameter int unsigned MAX_LEN       = 4,
  parameter int unsigned TIMEOUT_CHARS = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rx_done,
  input  logic [7:0]  uart_rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [2:0]  cmd_len,
  output logic [31:0] cmd_payload,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned ToCyc  = TIMEOUT_CHARS * 10 * (CLK_FRE / BPS) - 1;
  localparam logic [23:0] ToCycW = ToCyc[23:0];
  localparam logic [7:0]  MaxLenW = MAX_LEN[7:0];

  state_e      r_state;
  logic [7:0]  r_code;
  logic [2:0]  r_len;
  logic [31:0] r_payload;
  logic [7:0]  r_sum;
  logic [2:0]  r_idx;
  logic [23:0] r_to_cnt;

  logic        r_cmd_valid;
  logic [7:0]  r_cmd_code;
  logic [2:0]  r_cmd_len;
  logic [31:0] r_cmd_payload;
  logic        r_frame_err;
  logic [1:0]  r_err_code;

  logic [7:0]  w_sum_next;
  logic [2:0]  w_idx_next;

  assign w_sum_next = r_sum + uart_rx_data;
  assign w_idx_next = r_idx + 3'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= StIdle;
      r_code        <= '0;
      r_len         <= '0;
      r_payload     <= '0;
      r_sum         <= '0;
      r_idx         <= '0;
      r_to_cnt      <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_code    <= '0;
      r_cmd_len     <= '0;
      r_cmd_payload <= '0;
      r_frame_err   <= 1'b0;
      r_err_code    <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      // A byte arriving in the expiry cycle wins over the timeout.
      if (uart_rx_done) begin
        r_to_cnt <= '0;
        unique case (r_state)
          StIdle: begin
            if (uart_rx_data == HEADER) r_state <= StCmd;
          end
          StCmd: begin
            r_code  <= uart_rx_data;
            r_sum   <= uart_rx_data;
            r_state <= StLen;
          end
          StLen: begin
            if (uart_rx_data > MaxLenW) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ErrLen;
              r_state     <= StIdle;
            end else begin
              r_len     <= uart_rx_data[2:0];
              r_sum     <= w_sum_next;
              r_payload <= '0;
              r_idx     <= '0;
              r_state   <= (uart_rx_data == 8'd0) ? StChk : StPayload;
            end
          end
          StPayload: begin
            r_payload[{r_idx[1:0], 3'b000} +: 8] <= uart_rx_data;
            r_sum <= w_sum_next;
            r_idx <= w_idx_next;
            if (w_idx_next == r_len) r_state <= StChk;
          end
          StChk: begin
            if (uart_rx_data == r_sum) begin
              r_cmd_valid   <= 1'b1;
              r_cmd_code    <= r_code;
              r_cmd_len     <= r_len;
              r_cmd_payload <= r_payload;
            end else begin
              r_frame_err <= 1'b1;
              r_err_code  <= ErrChk;
            end
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end else if (r_state != StIdle) begin
        if (r_to_cnt == ToCycW) begin
          r_frame_err <= 1'b1;
          r_err_code  <= ErrTo;
          r_state     <= StIdle;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 24'd1;
        end
      end
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_code    = r_cmd_code;
  assign cmd_len     = r_cmd_len;
  assign cmd_payload = r_cmd_payload;
  assign frame_err   = r_frame_err;
  assign err_code    = r_err_code;
  assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  // Scaled clock/baud so that the timeout is 3*10*10 = 300 cycles.
  localparam int unsigned TbClkFre = 1000;
  localparam int unsigned TbBps    = 100;
  localparam int unsigned ToEvents = 3 * 10 * (TbClkFre / TbBps);
  localparam logic [7:0]  Hdr      = 8'hAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done;
  logic [7:0]  data;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .CLK_FRE      (TbClkFre),
    .BPS          (TbBps),
    .HEADER       (Hdr),
    .MAX_LEN      (4),
    .TIMEOUT_CHARS(3)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .uart_rx_done(done),
    .uart_rx_data(data),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  ecode;
    logic [7:0]  code;
    logic [2:0]  len;
    logic [31:0] pay;
    time         at;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  time  t_done;
  logic prev_strobe = 1'b0;

  // Reference state: what the outputs should hold after the next event.
  logic [7:0]  m_code = '0;
  logic [2:0]  m_len  = '0;
  logic [31:0] m_pay  = '0;
  logic [1:0]  m_err  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_err, input time at);
    exp_t e;
    e.is_err = is_err;
    e.ecode  = m_err;
    e.code   = m_code;
    e.len    = m_len;
    e.pay    = m_pay;
    e.at     = at;
    sb.push_back(e);
  endtask

  // Drives one byte strobe; the outcome (if any) is registered on the sampling edge.
  task automatic send_byte(input logic [7:0] b, input bit push, input bit is_err);
    @(negedge clk);
    done   = 1'b1;
    data   = b;
    t_done = $time + 5;
    if (push) push_exp(is_err, t_done);
    @(negedge clk);
    done = 1'b0;
    data = 8'($urandom);
    repeat ($urandom_range(0, 6)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic [7:0] lenb,
                            input logic [31:0] pay, input logic [7:0] chk_xor);
    logic [7:0] sum;
    send_byte(Hdr, 1'b0, 1'b0);
    send_byte(code, 1'b0, 1'b0);
    if (lenb > 8'd4) begin
      m_err = 2'd1;
      send_byte(lenb, 1'b1, 1'b1);
      return;
    end
    send_byte(lenb, 1'b0, 1'b0);
    sum = code + lenb;
    for (int i = 0; i < int'(lenb); i++) begin
      sum = sum + pay[8*i +: 8];
      send_byte(pay[8*i +: 8], 1'b0, 1'b0);
    end
    if (chk_xor == 8'd0) begin
      m_code = code;
      m_len  = lenb[2:0];
      m_pay  = '0;
      for (int i = 0; i < int'(lenb); i++) m_pay[8*i +: 8] = pay[8*i +: 8];
      send_byte(sum, 1'b1, 1'b0);
    end else begin
      m_err = 2'd2;
      send_byte(sum ^ chk_xor, 1'b1, 1'b1);
    end
  endtask

  task automatic send_stall(input logic [7:0] code, input logic [7:0] lenb, input int nbytes);
    send_byte(Hdr, 1'b0, 1'b0);
    send_byte(code, 1'b0, 1'b0);
    send_byte(lenb, 1'b0, 1'b0);
    for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    m_err = 2'd3;
    push_exp(1'b1, t_done + 10 * ToEvents);
    check("busy_mid_frame", {63'd0, busy}, 64'd1);
    repeat (ToEvents + 10) @(negedge clk);
    check("busy_after_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom); while (b == Hdr);
      send_byte(b, 1'b0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"},   {63'd0, cmd_valid}, 64'd0);
    check({tag, "_cmd_code"},    {56'd0, cmd_code}, 64'd0);
    check({tag, "_cmd_len"},     {61'd0, cmd_len}, 64'd0);
    check({tag, "_cmd_payload"}, {32'd0, cmd_payload}, 64'd0);
    check({tag, "_frame_err"},   {63'd0, frame_err}, 64'd0);
    check({tag, "_err_code"},    {62'd0, err_code}, 64'd0);
    check({tag, "_busy"},        {63'd0, busy}, 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes an outcome.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_strobe = 1'b0;
    end else begin
      if (prev_strobe) check("strobe_width", {63'd0, cmd_valid | frame_err}, 64'd0);
      if (cmd_valid || frame_err) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got valid=%0b err=%0b expected none at %0t",
                   cmd_valid, frame_err, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_exclusive", {63'd0, cmd_valid & frame_err}, 64'd0);
          check("strobe_kind",  {63'd0, frame_err}, {63'd0, e.is_err});
          check("err_code",     {62'd0, err_code}, {62'd0, e.ecode});
          check("cmd_code",     {56'd0, cmd_code}, {56'd0, e.code});
          check("cmd_len",      {61'd0, cmd_len}, {61'd0, e.len});
          check("cmd_payload",  {32'd0, cmd_payload}, {32'd0, e.pay});
          check("strobe_time",  64'($time - 5), 64'(e.at));
        end
      end
      prev_strobe = cmd_valid | frame_err;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    rst_n = 1'b0;
    done  = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases.
    send_frame(8'h01, 8'h02, 32'h0000_2010, 8'h00);
    send_frame(8'h05, 8'h00, 32'h0, 8'h00);
    send_frame(8'h01, 8'h01, 32'h0000_007F, 8'h80);
    send_frame(8'h02, 8'h05, 32'h0, 8'h00);
    send_frame(8'h03, 8'h00, 32'h0, 8'h00);
    send_stall(8'h01, 8'h02, 1);
    send_junk(0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    send_frame(8'hAA, 8'h04, 32'hAAAA_AAAA, 8'h00);
    send_frame(8'hFF, 8'h04, 32'hFFFF_FFFF, 8'h00);

    // Reset mid-payload: everything clears, nothing strobes.
    send_byte(Hdr, 1'b0, 1'b0);
    send_byte(8'h07, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    m_code = '0;
    m_len  = '0;
    m_pay  = '0;
    m_err  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h09, 8'h01, 32'h0000_0042, 8'h00);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 11);
      if (kind <= 5) begin
        send_frame(8'($urandom), 8'($urandom_range(0, 4)), $urandom, 8'h00);
      end else if (kind == 6 || kind == 7) begin
        send_frame(8'($urandom), 8'($urandom_range(0, 4)), $urandom,
                   8'($urandom_range(1, 255)));
      end else if (kind == 8) begin
        send_frame(8'($urandom), 8'($urandom_range(5, 255)), 32'h0, 8'h00);
      end else if (kind == 9) begin
        logic [7:0] l;
        l = 8'($urandom_range(1, 4));
        send_stall(8'($urandom), l, $urandom_range(0, int'(l) - 1));
      end else begin
        send_junk($urandom_range(1, 3));
        send_frame(8'($urandom), 8'($urandom_range(0, 4)), $urandom, 8'h00);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
